// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add is split into STAGES chunks of CHUNK bits. Each stage resolves
// one chunk and passes its carry to the next stage. Operand bits for the chunks
// that are still unresolved travel alongside the data in skew registers. Sum
// bits that are already resolved are kept in the same way.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
//   - The producer holds in_valid and its operands stable until it is accepted.
//   - The whole pipeline advances only when the output slot is empty or being
//     drained (advance = !out_valid || out_ready).
//   - in_ready equals advance. It is a combinational function of out_ready and
//     the registered output valid.
//   - While out_valid && !out_ready, every stage holds, including bubbles, and
//     the outputs stay stable.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    generate
        if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("pipelined_ripple_adder: WIDTH must be >= 2 and divisible by STAGES");
        end
    endgenerate

    // Per-stage registers: the valid bit, the skewed operands, the partial sum and the chunk carry.
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  bb_q  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] carry_q;
    logic              ovf_q;

    // Stage inputs, selected from the ports or from the previous stage.
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_bb  [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [STAGES-1:0] src_c;

    // Next-state values for each stage.
    logic [CHUNK:0]    chunk_res [STAGES];
    logic [WIDTH-1:0]  sum_d     [STAGES];
    logic [STAGES-1:0] carry_d;
    logic              ovf_d;

    logic advance;

    assign advance   = !valid_q[LAST] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign overflow  = ovf_q;

    // Apply the operand transform at the input, resolve one chunk per stage, and derive MSB overflow.
    always_comb begin
        src_a[0]   = a;
        src_bb[0]  = sub ? ~b : b;
        src_c[0]   = sub ? ~cin : cin;
        src_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_bb[k]  = bb_q[k-1];
            src_c[k]   = carry_q[k-1];
            src_sum[k] = sum_q[k-1];
        end
        carry_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk_res[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                         + {1'b0, src_bb[k][k*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, src_c[k]};
            sum_d[k]                   = src_sum[k];
            sum_d[k][k*CHUNK +: CHUNK] = chunk_res[k][CHUNK-1:0];
            carry_d[k]                 = chunk_res[k][CHUNK];
        end
        // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
        ovf_d = (chunk_res[LAST][CHUNK-1] ^ src_a[LAST][WIDTH-1] ^ src_bb[LAST][WIDTH-1])
              ^ chunk_res[LAST][CHUNK];
    end

    // Shift every stage one step when the pipeline can advance, and clear everything on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bb_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= src_a[k];
                bb_q[k]  <= src_bb[k];
                sum_q[k] <= sum_d[k];
            end
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and streaming checks for pipelined_ripple_adder (WIDTH=16, STAGES=4).
module tb_pipelined_ripple_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int LAT    = STAGES - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int nvec = 0;
    int nerr = 0;

    // Each entry holds {sum, cout, overflow}.
    logic [WIDTH+1:0] exp_q[$];

    pipelined_ripple_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
        $fatal(1, "watchdog");
    end

    // Flat reference: full-width add of the transformed operands.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
        logic [WIDTH-1:0] yy;
        logic             c0;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] low;
        yy   = s ? ~y : y;
        c0   = s ? ~c : c;
        full = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c0};
        low  = {1'b0, x[WIDTH-2:0]} + {1'b0, yy[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c0};
        return {full[WIDTH-1:0], full[WIDTH], low[WIDTH-1] ^ full[WIDTH]};
    endfunction

    // Driver: send one op into an empty pipeline and return the result and its latency in edges after accept.
    task automatic drive_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                            input logic xc, input logic xs,
                            output logic [WIDTH-1:0] o_sum, output logic o_cout,
                            output logic o_ovf, output int lat);
        @(negedge clk);
        a = xa; b = xb; cin = xc; sub = xs;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        #1;
        o_sum  = sum;
        o_cout = cout;
        o_ovf  = overflow;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL reset_initial: got valid=%b ready=%b sum=%h cout=%b ovf=%b, required 0 1 0000 0 0",
                     out_valid, in_ready, sum, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Put four ops in flight; after the fourth accept, the first is at the output.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 16'h1111 * 16'(i + 1); b = 16'h2222; cin = 1'b1; sub = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b1 || sum !== 16'h3334) begin
            nerr++;
            $display("FAIL reset_preload: got valid=%b sum=%h, required 1 3334", out_valid, sum);
        end
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL reset_midflight: got valid=%b ready=%b sum=%h cout=%b ovf=%b, required 0 1 0000 0 0",
                     out_valid, in_ready, sum, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL reset_no_stale: cycle %0d got out_valid=%b sum=%h, required 0", i, out_valid, sum);
            end
        end
    endtask

    task automatic test_single_add();
        logic [WIDTH-1:0] s;
        logic co, ov;
        int lat;
        drive_op(16'h0001, 16'h0002, 1'b0, 1'b0, s, co, ov, lat);
        nvec++;
        if (lat !== LAT) begin
            nerr++;
            $display("FAIL single_latency: got %0d edges after accept, required %0d", lat, LAT);
        end
        nvec++;
        if (s !== 16'h0003 || co !== 1'b0 || ov !== 1'b0) begin
            nerr++;
            $display("FAIL single_add: got sum=%h cout=%b ovf=%b, required 0003 0 0", s, co, ov);
        end
    endtask

    task automatic test_carry_chain();
        logic [WIDTH-1:0] s;
        logic co, ov;
        int lat;
        drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
        nvec++;
        if (lat !== LAT || s !== 16'h0000 || co !== 1'b1 || ov !== 1'b0) begin
            nerr++;
            $display("FAIL carry_ffff_1: got lat=%0d sum=%h cout=%b ovf=%b, required 3 0000 1 0", lat, s, co, ov);
        end
        drive_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
        nvec++;
        if (s !== 16'h8000 || co !== 1'b0 || ov !== 1'b1) begin
            nerr++;
            $display("FAIL carry_7fff_1: got sum=%h cout=%b ovf=%b, required 8000 0 1", s, co, ov);
        end
        drive_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, s, co, ov, lat);
        nvec++;
        if (s !== 16'hFFFF || co !== 1'b1 || ov !== 1'b0) begin
            nerr++;
            $display("FAIL carry_ffff_ffff_1: got sum=%h cout=%b ovf=%b, required ffff 1 0", s, co, ov);
        end
    endtask

    task automatic test_subtract();
        logic [WIDTH-1:0] s;
        logic co, ov;
        int lat;
        drive_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov, lat);
        nvec++;
        if (s !== 16'hFFFE || co !== 1'b0 || ov !== 1'b0) begin
            nerr++;
            $display("FAIL sub_5_7: got sum=%h cout=%b ovf=%b, required fffe 0 0", s, co, ov);
        end
        drive_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
        nvec++;
        if (s !== 16'h7FFF || co !== 1'b1 || ov !== 1'b1) begin
            nerr++;
            $display("FAIL sub_8000_1: got sum=%h cout=%b ovf=%b, required 7fff 1 1", s, co, ov);
        end
        drive_op(16'h0010, 16'h0003, 1'b1, 1'b1, s, co, ov, lat);
        nvec++;
        if (s !== 16'h000C || co !== 1'b1 || ov !== 1'b0) begin
            nerr++;
            $display("FAIL sub_borrow_in: got sum=%h cout=%b ovf=%b, required 000c 1 0", s, co, ov);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] va [8];
        logic [WIDTH-1:0] vb [8];
        logic             vc [8];
        logic             vs [8];
        int got;
        for (int i = 0; i < 8; i++) begin
            va[i] = WIDTH'($urandom_range(0, 65535));
            vb[i] = WIDTH'($urandom_range(0, 65535));
            vc[i] = 1'($urandom_range(0, 1));
            vs[i] = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        got = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if (c < 8) begin
                a = va[c]; b = vb[c]; cin = vc[c]; sub = vs[c];
                in_valid = 1'b1;
                exp_q.push_back(model(va[c], vb[c], vc[c], vs[c]));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                nvec++;
                if (c !== LAT + 1 + got) begin
                    nerr++;
                    $display("FAIL stream_timing: result %0d at cycle %0d, required cycle %0d", got, c, LAT + 1 + got);
                end
                nvec++;
                if ({sum, cout, overflow} !== exp_q[0]) begin
                    nerr++;
                    $display("FAIL stream_data: result %0d got %h, required %h", got, {sum, cout, overflow}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                got++;
            end
        end
        in_valid = 1'b0;
        nvec++;
        if (got !== 8) begin
            nerr++;
            $display("FAIL stream_count: got %0d results, required 8", got);
        end
    endtask

    // Traffic with backpressure: a fixed 3-cycle stall (random_mode=0) or random valid/ready.
    task automatic run_traffic(input int n_ops, input bit random_mode);
        int sent, recv, cyc;
        logic [WIDTH-1:0] ca, cb;
        logic cc, cs;
        sent = 0; recv = 0; cyc = 0;
        exp_q.delete();
        ca = WIDTH'($urandom_range(0, 65535)); cb = WIDTH'($urandom_range(0, 65535));
        cc = 1'($urandom_range(0, 1));         cs = 1'($urandom_range(0, 1));
        while ((sent < n_ops || exp_q.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            out_ready = random_mode ? ($urandom_range(0, 3) != 0) : !(cyc >= 5 && cyc < 8);
            in_valid  = (sent < n_ops) && (random_mode ? ($urandom_range(0, 4) != 0) : 1'b1);
            a = ca; b = cb; cin = cc; sub = cs;
            #1;
            if (out_valid) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL traffic_spurious: got result %h with nothing outstanding, required none", {sum, cout, overflow});
                end else if ({sum, cout, overflow} !== exp_q[0]) begin
                    nerr++;
                    $display("FAIL traffic_data: result %0d got %h, required %h", recv, {sum, cout, overflow}, exp_q[0]);
                end
                if (!out_ready) begin
                    nvec++;
                    if (in_ready !== 1'b0) begin
                        nerr++;
                        $display("FAIL traffic_stall_ready: cycle %0d got in_ready=%b, required 0", cyc, in_ready);
                    end
                end else if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    recv++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ca, cb, cc, cs));
                sent++;
                ca = WIDTH'($urandom_range(0, 65535)); cb = WIDTH'($urandom_range(0, 65535));
                cc = 1'($urandom_range(0, 1));         cs = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        nvec++;
        if (sent !== n_ops || recv !== n_ops || exp_q.size() !== 0) begin
            nerr++;
            $display("FAIL traffic_drain: got sent=%0d recv=%0d left=%0d, required %0d %0d 0",
                     sent, recv, exp_q.size(), n_ops, n_ops);
        end
    endtask

    task automatic test_backpressure();
        run_traffic(10, 1'b0);
        run_traffic(200, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry_chain();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
